// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the MEM-stage core port and the loader, with a locked loader burst mode.
// Optional build macro DMEM_ARB_RR_EN: round-robin IDLE contention (default build: the core has fixed priority).
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_YIELD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             burst_full;

`ifdef DMEM_ARB_RR_EN
  logic last_ldr_q, last_ldr_d;
`endif

  assign burst_full = (cnt_q == CNT_W'(MAX_BURST));

  // Grant selection and next-state; reset masks all grants
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_ldr_d = last_ldr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (core_req && ldr_req) begin
`ifdef DMEM_ARB_RR_EN
          core_gnt = last_ldr_q;
          ldr_gnt  = ~last_ldr_q;
`else
          core_gnt = 1'b1;
`endif
        end else begin
          core_gnt = core_req;
          ldr_gnt  = ldr_req;
        end
        if (ldr_gnt && ldr_lock) begin
          state_d = ST_LOCK;
          cnt_d   = CNT_W'(1);
        end
`ifdef DMEM_ARB_RR_EN
        if (core_gnt || ldr_gnt) last_ldr_d = ldr_gnt;
`endif
      end
      ST_LOCK: begin
        if (ldr_lock && burst_full && core_req) begin
          state_d = ST_YIELD;
          cnt_d   = '0;
        end else begin
          ldr_gnt = ldr_req;
          if (!ldr_lock) state_d = ST_IDLE;
          if (ldr_gnt && !burst_full) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_YIELD: begin
        core_gnt = core_req;
        cnt_d    = '0;
        state_d  = ldr_lock ? ST_LOCK : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      core_gnt = 1'b0;
      ldr_gnt  = 1'b0;
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign mem_read   = (core_gnt & ~core_we) | (ldr_gnt & ~ldr_we);
  assign mem_write  = (core_gnt & core_we) | (ldr_gnt & ldr_we);
  assign mem_addr   = ldr_gnt ? ldr_addr  : core_addr;
  assign mem_wdata  = ldr_gnt ? ldr_wdata : core_wdata;

  // State, burst counter and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      ldr_rvalid  <= 1'b0;
      ldr_rdata   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_rvalid <= core_gnt & ~core_we;
      ldr_rvalid  <= ldr_gnt & ~ldr_we;
      if (core_gnt && !core_we) core_rdata <= mem_rdata;
      if (ldr_gnt && !ldr_we)   ldr_rdata  <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) last_ldr_q <= 1'b1;
    else       last_ldr_q <= last_ldr_d;
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (fixed-priority build, MAX_BURST=4) with a small memory model.
module tb_dmem_port_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt, core_stall, core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              ldr_req, ldr_we, ldr_lock;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt, ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    step(); step();
    checks++; if (core_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid core=%b ldr=%b want 0 0", core_rvalid, ldr_rvalid); end
    checks++; if (core_rdata !== 64'd0 || ldr_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata core=%h ldr=%h want 0 0", core_rdata, ldr_rdata); end
    core_req = 1; ldr_req = 1; #1;
    checks++; if (core_gnt !== 1'b0 || ldr_gnt !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_gnt cg=%b lg=%b rd=%b wr=%b want 0 0 0 0", core_gnt, ldr_gnt, mem_read, mem_write); end
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", core_stall); end
    step();
    reset = 0; idle_inputs(); #1;
  endtask

  task automatic test_core_read();
    core_req = 1; core_we = 0; core_addr = 8'd5; #1;
    checks++; if (core_gnt !== 1'b1 || mem_read !== 1'b1 || core_stall !== 1'b0 || mem_addr !== 8'd5) begin errors++; $display("FAIL core_read_gnt cg=%b rd=%b st=%b addr=%0d want 1 1 0 5", core_gnt, mem_read, core_stall, mem_addr); end
    step(); core_req = 0;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 64'd5) begin errors++; $display("FAIL core_read_data rv=%b rdata=%h want 1 5", core_rvalid, core_rdata); end
    step();
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== 64'd5) begin errors++; $display("FAIL core_read_hold rv=%b rdata=%h want 0 5", core_rvalid, core_rdata); end
  endtask

  task automatic test_contention();
    core_req = 1; core_we = 1; core_addr = 8'd3; core_wdata = 64'hAA;
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'd4; #1;
    checks++; if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL contend_core cg=%b lg=%b wr=%b rd=%b want 1 0 1 0", core_gnt, ldr_gnt, mem_write, mem_read); end
    checks++; if (mem_addr !== 8'd3 || mem_wdata !== 64'hAA) begin errors++; $display("FAIL contend_bus addr=%0d wdata=%h want 3 aa", mem_addr, mem_wdata); end
    step(); core_req = 0; #1;
    checks++; if (ldr_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 8'd4) begin errors++; $display("FAIL contend_ldr lg=%b rd=%b addr=%0d want 1 1 4", ldr_gnt, mem_read, mem_addr); end
    step(); ldr_req = 0;
    checks++; if (ldr_rvalid !== 1'b1 || ldr_rdata !== 64'd4 || core_rvalid !== 1'b0) begin errors++; $display("FAIL contend_ldr_data lrv=%b lrdata=%h crv=%b want 1 4 0", ldr_rvalid, ldr_rdata, core_rvalid); end
    core_req = 1; core_we = 0; core_addr = 8'd3;
    step(); core_req = 0;
    checks++; if (core_rdata !== 64'hAA || core_rvalid !== 1'b1) begin errors++; $display("FAIL write_commit rdata=%h rv=%b want aa 1", core_rdata, core_rvalid); end
    step(); idle_inputs();
  endtask

  task automatic test_burst();
    logic exp_l [10] = '{1,1,1,0,0,1,1,1,1,0};
    logic exp_c [10] = '{0,0,0,0,1,0,0,0,0,0};
    ldr_req = 1; ldr_lock = 1; ldr_addr = 8'd10; #1;
    checks++; if (ldr_gnt !== 1'b1) begin errors++; $display("FAIL burst_start lg=%b want 1", ldr_gnt); end
    step();
    core_req = 1; core_addr = 8'd20;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (ldr_gnt !== exp_l[i] || core_gnt !== exp_c[i] || core_stall !== ~exp_c[i]) begin
        errors++; $display("FAIL burst_cyc%0d lg=%b cg=%b st=%b want %b %b %b", i, ldr_gnt, core_gnt, core_stall, exp_l[i], exp_c[i], ~exp_c[i]);
      end
      step();
    end
    idle_inputs(); step();
  endtask

  task automatic test_lock_drop();
    ldr_req = 1; ldr_lock = 1; ldr_addr = 8'd11;
    step();
    core_req = 1; core_addr = 8'd21; #1;
    checks++; if (ldr_gnt !== 1'b1 || core_gnt !== 1'b0 || core_stall !== 1'b1) begin errors++; $display("FAIL lock2 lg=%b cg=%b st=%b want 1 0 1", ldr_gnt, core_gnt, core_stall); end
    step(); ldr_lock = 0; #1;
    checks++; if (ldr_gnt !== 1'b1 || core_gnt !== 1'b0) begin errors++; $display("FAIL lock_drop_honour lg=%b cg=%b want 1 0", ldr_gnt, core_gnt); end
    step(); #1;
    checks++; if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0 || mem_addr !== 8'd21) begin errors++; $display("FAIL lock_drop_idle cg=%b lg=%b addr=%0d want 1 0 21", core_gnt, ldr_gnt, mem_addr); end
    step(); idle_inputs(); step();
  endtask

  task automatic test_reset_mid();
    ldr_req = 1; ldr_lock = 1; ldr_we = 0; ldr_addr = 8'd7;
    step();
    reset = 1; core_req = 1; #1;
    checks++; if (core_gnt !== 1'b0 || ldr_gnt !== 1'b0 || mem_read !== 1'b0 || core_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt cg=%b lg=%b rd=%b st=%b want 0 0 0 1", core_gnt, ldr_gnt, mem_read, core_stall); end
    step();
    checks++; if (ldr_rvalid !== 1'b0 || ldr_rdata !== 64'd0) begin errors++; $display("FAIL rst_mid_rv lrv=%b lrdata=%h want 0 0", ldr_rvalid, ldr_rdata); end
    reset = 0; #1;
    checks++; if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_idle cg=%b lg=%b want 1 0", core_gnt, ldr_gnt); end
    step(); idle_inputs(); step();
    checks++; if (ldr_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_norv lrv=%b want 0", ldr_rvalid); end
  endtask

  task automatic test_yield_no_core();
    logic exp_l [5] = '{1,1,1,1,0};
    ldr_req = 1; ldr_lock = 1; ldr_addr = 8'd12;
    for (int i = 0; i < 4; i++) step();
    core_req = 1; #1;
    checks++; if (ldr_gnt !== 1'b0 || core_gnt !== 1'b0) begin errors++; $display("FAIL yield_enter lg=%b cg=%b want 0 0", ldr_gnt, core_gnt); end
    step(); core_req = 0; #1;
    checks++; if (ldr_gnt !== 1'b0 || core_gnt !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL yield_lost lg=%b cg=%b rd=%b wr=%b want 0 0 0 0", ldr_gnt, core_gnt, mem_read, mem_write); end
    step(); core_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ldr_gnt !== exp_l[i] || core_gnt !== 1'b0) begin
        errors++; $display("FAIL yield_restart%0d lg=%b cg=%b want %b 0", i, ldr_gnt, core_gnt, exp_l[i]);
      end
      step();
    end
    idle_inputs(); step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'(i);
    test_reset();
    test_core_read();
    test_contention();
    test_burst();
    test_lock_drop();
    test_reset_mid();
    test_yield_no_core();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
